// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY HS clock-lane transmitter.
// Optional feature macro: DPHY_CLK_ULPS_EN adds the ultra-low-power states.
package dphy_tx_pkg;

   // Clock-lane FSM states; the ULPS states exist only when the feature is built in.
   typedef enum logic [3:0] {
      ST_STOP,
      ST_HS_RQST,
      ST_BRIDGE,
      ST_HS_ZERO,
      ST_HS_PRE,
      ST_HS_CLK,
      ST_HS_POST,
      ST_HS_TRAIL,
      ST_HS_EXIT
`ifdef DPHY_CLK_ULPS_EN
      ,
      ST_ULPS_RQST,
      ST_ULPS,
      ST_ULPS_EXIT
`endif
   } dphy_state_e;

   // 0x55 keeps the serial stream alternating across byte boundaries (bit 0 first).
   localparam logic [7:0] HS_TOGGLE_PATTERN = 8'h55;
   localparam logic [7:0] HS_ZERO_PATTERN   = 8'h00;

   // Length of the LP-10 mark that ends ULPS before returning to Stop.
   localparam int ULPS_EXIT_CYCLES = 255;

   // Reload value for the shared down-counter: a state lasts max(cycles,1)
   // cycles, and the counter expires when it reads zero.
   function automatic logic [7:0] tmr_load(input int cycles);
      if (cycles <= 1) begin
         return 8'd0;
      end else if (cycles >= 256) begin
         return 8'd255;
      end else begin
         return 8'(cycles - 1);
      end
   endfunction

endpackage

// File: rtl/dphy_hs_clk_tx.sv
// D-PHY continuous HS clock-lane transmitter sequencer.
// Drives LP line levels, the HS driver enable and the 8-bit pattern for an
// 8:1 serializer. Optional feature macro: DPHY_CLK_ULPS_EN (ULPS entry/exit).
//
// Handshake: hs_req_i is a level request. The block answers with clk_ready_o,
// which rises only once the HS clock has toggled for T_CLK_PRE cycles and
// stays high exactly while the lane is in HS_CLK. Dropping hs_req_i (or never
// holding it past one cycle) always runs the full entry then the full exit;
// a request seen after the exit has started is honoured only back in Stop.
module dphy_hs_clk_tx
   import dphy_tx_pkg::*;
#(
   parameter int T_LPX         = 2,
   parameter int T_CLK_PREPARE = 2,
   parameter int T_CLK_ZERO    = 8,
   parameter int T_CLK_PRE     = 2,
   parameter int T_CLK_POST    = 16,
   parameter int T_CLK_TRAIL   = 2,
   parameter int T_HS_EXIT     = 3
) (
   input  logic       byte_clk_i,
   input  logic       rst_i,
   input  logic       hs_req_i,
`ifdef DPHY_CLK_ULPS_EN
   input  logic       ulps_req_i,
   output logic       ulps_active_o,
`endif
   output logic       clk_ready_o,
   output logic       stop_o,
   output logic       hs_en_o,
   output logic [7:0] hs_data_o,
   output logic       lp_p_o,
   output logic       lp_n_o
);

   localparam logic [7:0] L_LPX     = tmr_load(T_LPX);
   localparam logic [7:0] L_PREP    = tmr_load(T_CLK_PREPARE);
   localparam logic [7:0] L_ZERO    = tmr_load(T_CLK_ZERO);
   localparam logic [7:0] L_PRE     = tmr_load(T_CLK_PRE);
   localparam logic [7:0] L_POST    = tmr_load(T_CLK_POST);
   localparam logic [7:0] L_TRAIL   = tmr_load(T_CLK_TRAIL);
   localparam logic [7:0] L_EXIT    = tmr_load(T_HS_EXIT);
`ifdef DPHY_CLK_ULPS_EN
   localparam logic [7:0] L_UEXIT   = tmr_load(ULPS_EXIT_CYCLES);
`endif

   dphy_state_e r_state;
   dphy_state_e w_next;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_next;
   logic        w_expired;

   logic        r_lp_p, r_lp_n, r_hs_en, r_clk_ready, r_stop;
   logic [7:0]  r_hs_data;
   logic        w_lp_p, w_lp_n, w_hs_en, w_clk_ready, w_stop;
   logic [7:0]  w_hs_data;
`ifdef DPHY_CLK_ULPS_EN
   logic        r_ulps_active;
   logic        w_ulps_active;
`endif

   assign w_expired = (r_cnt == 8'd0);

   // Next state, timer reload on entry, and output decode of the state being entered.
   always_comb begin
      w_next      = r_state;
      w_cnt_next  = w_expired ? 8'd0 : (r_cnt - 8'd1);
      w_lp_p      = 1'b1;
      w_lp_n      = 1'b1;
      w_hs_en     = 1'b0;
      w_hs_data   = HS_ZERO_PATTERN;
      w_clk_ready = 1'b0;
      w_stop      = 1'b0;
`ifdef DPHY_CLK_ULPS_EN
      w_ulps_active = 1'b0;
`endif

      case (r_state)
         ST_STOP: begin
`ifdef DPHY_CLK_ULPS_EN
            // An HS request wins over a simultaneous ULPS request.
            if (hs_req_i) begin
               w_next = ST_HS_RQST;
            end else if (ulps_req_i) begin
               w_next = ST_ULPS_RQST;
            end
`else
            if (hs_req_i) begin
               w_next = ST_HS_RQST;
            end
`endif
         end
         ST_HS_RQST:  if (w_expired) w_next = ST_BRIDGE;
         ST_BRIDGE:   if (w_expired) w_next = ST_HS_ZERO;
         ST_HS_ZERO:  if (w_expired) w_next = ST_HS_PRE;
         ST_HS_PRE:   if (w_expired) w_next = ST_HS_CLK;
         ST_HS_CLK:   if (!hs_req_i) w_next = ST_HS_POST;
         ST_HS_POST:  if (w_expired) w_next = ST_HS_TRAIL;
         ST_HS_TRAIL: if (w_expired) w_next = ST_HS_EXIT;
         ST_HS_EXIT:  if (w_expired) w_next = ST_STOP;
`ifdef DPHY_CLK_ULPS_EN
         ST_ULPS_RQST: if (w_expired) w_next = ST_ULPS;
         ST_ULPS:      if (!ulps_req_i) w_next = ST_ULPS_EXIT;
         ST_ULPS_EXIT: if (w_expired) w_next = ST_STOP;
`endif
         default:     w_next = ST_STOP;
      endcase

      // There are no self-transitions, so a state change is always a fresh entry.
      if (w_next != r_state) begin
         case (w_next)
            ST_HS_RQST:   w_cnt_next = L_LPX;
            ST_BRIDGE:    w_cnt_next = L_PREP;
            ST_HS_ZERO:   w_cnt_next = L_ZERO;
            ST_HS_PRE:    w_cnt_next = L_PRE;
            ST_HS_POST:   w_cnt_next = L_POST;
            ST_HS_TRAIL:  w_cnt_next = L_TRAIL;
            ST_HS_EXIT:   w_cnt_next = L_EXIT;
`ifdef DPHY_CLK_ULPS_EN
            ST_ULPS_RQST: w_cnt_next = L_LPX;
            ST_ULPS_EXIT: w_cnt_next = L_UEXIT;
`endif
            default:      w_cnt_next = 8'd0;
         endcase
      end

      case (w_next)
         ST_STOP: begin
            w_stop = 1'b1;
         end
         ST_HS_RQST: begin
            w_lp_p = 1'b0;
         end
         ST_BRIDGE: begin
            w_lp_p = 1'b0;
            w_lp_n = 1'b0;
         end
         ST_HS_ZERO, ST_HS_TRAIL: begin
            w_lp_p  = 1'b0;
            w_lp_n  = 1'b0;
            w_hs_en = 1'b1;
         end
         ST_HS_PRE, ST_HS_POST: begin
            w_lp_p    = 1'b0;
            w_lp_n    = 1'b0;
            w_hs_en   = 1'b1;
            w_hs_data = HS_TOGGLE_PATTERN;
         end
         ST_HS_CLK: begin
            w_lp_p      = 1'b0;
            w_lp_n      = 1'b0;
            w_hs_en     = 1'b1;
            w_hs_data   = HS_TOGGLE_PATTERN;
            w_clk_ready = 1'b1;
         end
`ifdef DPHY_CLK_ULPS_EN
         ST_ULPS_RQST, ST_ULPS_EXIT: begin
            w_lp_n = 1'b0;
         end
         ST_ULPS: begin
            w_lp_p        = 1'b0;
            w_lp_n        = 1'b0;
            w_ulps_active = 1'b1;
         end
`endif
         default: begin
            // HS_EXIT: LP-11 but not yet idle.
         end
      endcase
   end

   // State and shared timer register.
   always_ff @(posedge byte_clk_i) begin
      if (rst_i) begin
         r_state <= ST_STOP;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Registered outputs so the lane pins change cleanly with the state.
   always_ff @(posedge byte_clk_i) begin
      if (rst_i) begin
         r_lp_p      <= 1'b1;
         r_lp_n      <= 1'b1;
         r_hs_en     <= 1'b0;
         r_hs_data   <= HS_ZERO_PATTERN;
         r_clk_ready <= 1'b0;
         r_stop      <= 1'b1;
`ifdef DPHY_CLK_ULPS_EN
         r_ulps_active <= 1'b0;
`endif
      end else begin
         r_lp_p      <= w_lp_p;
         r_lp_n      <= w_lp_n;
         r_hs_en     <= w_hs_en;
         r_hs_data   <= w_hs_data;
         r_clk_ready <= w_clk_ready;
         r_stop      <= w_stop;
`ifdef DPHY_CLK_ULPS_EN
         r_ulps_active <= w_ulps_active;
`endif
      end
   end

   assign lp_p_o      = r_lp_p;
   assign lp_n_o      = r_lp_n;
   assign hs_en_o     = r_hs_en;
   assign hs_data_o   = r_hs_data;
   assign clk_ready_o = r_clk_ready;
   assign stop_o      = r_stop;
`ifdef DPHY_CLK_ULPS_EN
   assign ulps_active_o = r_ulps_active;
`endif

endmodule

// File: tb/tb_dphy_hs_clk_tx.sv
// Bench for dphy_hs_clk_tx: default-parameter instance driven from a vector
// table through an expected-value queue, plus a second instance with
// T_CLK_ZERO=0 / T_CLK_POST=255 and (when DPHY_CLK_ULPS_EN is set) a ULPS run.
module tb_dphy_hs_clk_tx;

   // Packed output view: {lp_p, lp_n, hs_en, hs_data[7:0], clk_ready, stop}
   localparam logic [12:0] E_STOP = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
   localparam logic [12:0] E_RQST = {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
   localparam logic [12:0] E_BRDG = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
   localparam logic [12:0] E_ZERO = {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
   localparam logic [12:0] E_TOG  = {1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
   localparam logic [12:0] E_CLK  = {1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
   localparam logic [12:0] E_EXIT = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
   localparam logic [12:0] E_U10  = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

   typedef struct {
      logic        rst;
      logic        req;
      logic [12:0] exp;
      int          tag;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 1: default parameters
   logic       rst, hs_req;
   logic       clk_ready, stop, hs_en, lp_p, lp_n;
   logic [7:0] hs_data;
   // Instance 2: boundary parameters
   logic       rst2, hs_req2;
   logic       clk_ready2, stop2, hs_en2, lp_p2, lp_n2;
   logic [7:0] hs_data2;
`ifdef DPHY_CLK_ULPS_EN
   logic ulps_req, ulps_active, ulps_req2, ulps_active2;
`endif

   dphy_hs_clk_tx u_dut (
      .byte_clk_i  (clk),
      .rst_i       (rst),
      .hs_req_i    (hs_req),
`ifdef DPHY_CLK_ULPS_EN
      .ulps_req_i   (ulps_req),
      .ulps_active_o(ulps_active),
`endif
      .clk_ready_o (clk_ready),
      .stop_o      (stop),
      .hs_en_o     (hs_en),
      .hs_data_o   (hs_data),
      .lp_p_o      (lp_p),
      .lp_n_o      (lp_n)
   );

   dphy_hs_clk_tx #(.T_CLK_ZERO(0), .T_CLK_POST(255)) u_dut2 (
      .byte_clk_i  (clk),
      .rst_i       (rst2),
      .hs_req_i    (hs_req2),
`ifdef DPHY_CLK_ULPS_EN
      .ulps_req_i   (ulps_req2),
      .ulps_active_o(ulps_active2),
`endif
      .clk_ready_o (clk_ready2),
      .stop_o      (stop2),
      .hs_en_o     (hs_en2),
      .hs_data_o   (hs_data2),
      .lp_p_o      (lp_p2),
      .lp_n_o      (lp_n2)
   );

   int          tests_run    = 0;
   int          tests_failed = 0;
   vec_t        vecs[$];
   logic [12:0] exp_q[$];

   function automatic logic [12:0] pack1();
      return {lp_p, lp_n, hs_en, hs_data, clk_ready, stop};
   endfunction

   function automatic logic [12:0] pack2();
      return {lp_p2, lp_n2, hs_en2, hs_data2, clk_ready2, stop2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic q, input logic [12:0] e, input int n, input int tag);
      for (int i = 0; i < n; i++) vecs.push_back('{r, q, e, tag});
   endtask

   // Watchdog: the run is short, so anything this long is a hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [12:0] got, e;
      logic [12:0] d2_exp[8];
      int n;

      rst = 1'b1; hs_req = 1'b0; rst2 = 1'b1; hs_req2 = 1'b0;
`ifdef DPHY_CLK_ULPS_EN
      ulps_req = 1'b0; ulps_req2 = 1'b0;
`endif

      // Reset, then a held request: full entry and a 16-cycle post on drop.
      add(1, 0, E_STOP, 2, 1);
      add(0, 0, E_STOP, 2, 2);
      add(0, 1, E_RQST, 2, 3);
      add(0, 1, E_BRDG, 2, 4);
      add(0, 1, E_ZERO, 8, 5);
      add(0, 1, E_TOG,  2, 6);
      add(0, 1, E_CLK,  4, 7);
      add(0, 0, E_TOG, 16, 8);
      add(0, 0, E_ZERO, 2, 9);
      add(0, 0, E_EXIT, 3, 10);
      add(0, 0, E_STOP, 3, 11);
      // One-cycle pulse: complete entry, one HS_CLK cycle, complete exit (36 cycles).
      add(0, 1, E_RQST, 1, 12);
      add(0, 0, E_RQST, 1, 12);
      add(0, 0, E_BRDG, 2, 13);
      add(0, 0, E_ZERO, 8, 14);
      add(0, 0, E_TOG,  2, 15);
      add(0, 0, E_CLK,  1, 16);
      add(0, 0, E_TOG, 16, 17);
      add(0, 0, E_ZERO, 2, 18);
      add(0, 0, E_EXIT, 3, 19);
      add(0, 0, E_STOP, 2, 20);
      // Reset during HS_CLK with the request held, then re-entry.
      add(0, 1, E_RQST, 2, 21);
      add(0, 1, E_BRDG, 2, 22);
      add(0, 1, E_ZERO, 8, 23);
      add(0, 1, E_TOG,  2, 24);
      add(0, 1, E_CLK,  3, 25);
      add(1, 1, E_STOP, 1, 26);
      add(0, 1, E_RQST, 2, 27);
      add(0, 1, E_BRDG, 2, 28);
      add(0, 1, E_ZERO, 8, 29);
      add(0, 1, E_TOG,  2, 30);
      add(0, 1, E_CLK,  2, 31);
      // Request re-raised during exit: ignored until Stop, then re-entry next cycle.
      add(0, 0, E_TOG,  1, 32);
      add(0, 1, E_TOG, 15, 33);
      add(0, 1, E_ZERO, 2, 34);
      add(0, 1, E_EXIT, 3, 35);
      add(0, 1, E_STOP, 1, 36);
      add(0, 1, E_RQST, 1, 37);
      add(1, 0, E_STOP, 2, 38);

      for (int i = 0; i < vecs.size(); i++) begin
         rst    = vecs[i].rst;
         hs_req = vecs[i].req;
         exp_q.push_back(vecs[i].exp);
         tick();
         got = pack1();
         if (exp_q.size() == 0) begin
            check_int($sformatf("vec%0d_queue", i), 0, 1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("vec%0d_tag%0d", i, vecs[i].tag), got, e);
         end
      end
      check_int("queue_drained", exp_q.size(), 0);

      // Boundary instance: one-cycle HS_ZERO and a 255-cycle post without wrap.
      d2_exp = '{E_RQST, E_RQST, E_BRDG, E_BRDG, E_ZERO, E_TOG, E_TOG, E_CLK};
      tick();
      check("d2_reset", pack2(), E_STOP);
      rst2 = 1'b0; hs_req2 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("d2_entry%0d", i), pack2(), d2_exp[i]);
      end
      hs_req2 = 1'b0;
      tick();
      n = 0;
      while (pack2() === E_TOG && n < 300) begin
         n++;
         tick();
      end
      check_int("d2_post_len", n, 255);
      check("d2_trail", pack2(), E_ZERO);
      tick(); tick(); tick(); tick(); tick();
      check("d2_stop", pack2(), E_STOP);

`ifdef DPHY_CLK_ULPS_EN
      // ULPS: request held 20 cycles, then 255-cycle LP-10 exit back to Stop.
      rst = 1'b0; hs_req = 1'b0; ulps_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i < 2) check($sformatf("ulps_rqst%0d", i), {ulps_active, pack1()}, {1'b0, E_U10});
         else       check($sformatf("ulps_hold%0d", i), {ulps_active, pack1()}, {1'b1, E_BRDG});
      end
      ulps_req = 1'b0;
      tick();
      n = 0;
      while ({ulps_active, pack1()} === {1'b0, E_U10} && n < 300) begin
         n++;
         tick();
      end
      check_int("ulps_exit_len", n, 255);
      check("ulps_stop", pack1(), E_STOP);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
